// File: rtl/rr_mux_4to1.sv
// Four-channel round-robin merger with registered output and source index.
// Channel k is granted in scan order after the last winner. With GRANT_BEATS>1
// a winner keeps the grant for up to GRANT_BEATS consecutive beats.
module rr_mux_4to1 #(
  parameter int WIDTH       = 8,
  parameter int GRANT_BEATS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  localparam int CW = $clog2(GRANT_BEATS + 1);

  typedef enum logic {ARB, LOCK} state_t;

  state_t        state, state_nxt;
  logic [1:0]    last_grant;
  logic [1:0]    lock_ch;
  logic [CW-1:0] beat_cnt;

  logic          load_en;
  logic          lock_hold;
  logic          arb_any;
  logic [1:0]    arb_g;
  logic [1:0]    grant;
  logic          grant_any;
  logic          xfer;
  logic [1:0]    scan_idx;
  logic [WIDTH-1:0] grant_data;

  // Round-robin scan starting just after the previous winner, wrapping 3 -> 0
  always_comb begin
    arb_any  = 1'b0;
    arb_g    = last_grant;
    scan_idx = last_grant;
    for (int i = 1; i <= 4; i++) begin
      scan_idx = last_grant + 2'(i);
      if (!arb_any && in_valid[scan_idx]) begin
        arb_any = 1'b1;
        arb_g   = scan_idx;
      end
    end
  end

  // Grant selection, handshake and next-state; a dropped lock falls back to the scan
  always_comb begin
    load_en   = !out_valid || out_ready;
    lock_hold = (state == LOCK) && in_valid[lock_ch];
    grant     = lock_hold ? lock_ch : arb_g;
    grant_any = lock_hold || arb_any;
    in_ready  = 4'b0000;
    if (!rst && load_en && grant_any)
      in_ready[grant] = 1'b1;
    xfer       = |in_ready;
    grant_data = in_data[grant*WIDTH +: WIDTH];
    state_nxt  = state;
    if (load_en) begin
      if (xfer) begin
        if (lock_hold)
          state_nxt = (beat_cnt + CW'(1) == CW'(GRANT_BEATS)) ? ARB : LOCK;
        else
          state_nxt = (GRANT_BEATS > 1) ? LOCK : ARB;
      end else if (state == LOCK) begin
        state_nxt = ARB;
      end
    end
  end

  // Arbitration bookkeeping: winner, lock channel and burst length; held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      last_grant <= 2'd3;
      lock_ch    <= 2'd0;
      beat_cnt   <= '0;
    end else if (load_en) begin
      state <= state_nxt;
      if (xfer) begin
        last_grant <= grant;
        lock_ch    <= grant;
        beat_cnt   <= lock_hold ? beat_cnt + CW'(1) : CW'(1);
      end
    end
  end

  // Output register: load on transfer, empty on idle load, hold under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= grant_data;
        out_sel  <= grant;
      end
    end
  end

endmodule
